// File: rtl/cpc_ram_pkg.sv
// Shared types and constants for the CPC RAM-config capture path:
// FSM state encoding, payload width and the Gate Array RAM-config decode.
package cpc_ram_pkg;

  localparam int         CFG_W   = 6;
  localparam logic [1:0] CFG_SEL = 2'b11;
  localparam logic       CFG_A15 = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_QUAL    = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_HOLD    = 2'b11
  } state_e;

  // True when an I/O write targets the Gate Array RAM-config register.
  function automatic logic cfg_decode(input logic a15, input logic [7:0] d);
    return (a15 == CFG_A15) && (d[7:6] == CFG_SEL);
  endfunction

endpackage

// File: rtl/cpc_sync_bit.sv
// N-stage synchroniser for one asynchronous bus bit; resets to the
// inactive (high) level so active-low strobes stay deasserted.
module cpc_sync_bit #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift chain, oldest sample at the top.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {N{1'b1}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/cpc_ioreq_cfg_capture.sv
// Samples the Z80 expansion bus, glitch-filters the I/O write strobe and
// captures Gate Array RAM-config writes, with a shadow copy and debug counters.
module cpc_ioreq_cfg_capture
  import cpc_ram_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IOREQ_B,
  input  logic             WR_B,
  input  logic             A15,
  input  logic [7:0]       D,
  input  logic             BUS_RESET_B,
  output logic             cfg_we,
  output logic [CFG_W-1:0] cfg_data,
  output logic [CFG_W-1:0] ramcfg,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rej_count,
  output logic [CNT_W-1:0] glitch_count
);

  localparam int NBITS = 12;
  localparam int QW    = $clog2(FILTER_LEN + 1);

  logic [NBITS-1:0] raw_s;
  logic [NBITS-1:0] sync_s;
  logic [7:0]       d_s;
  logic             ioreq_b_s;
  logic             wr_b_s;
  logic             a15_s;
  logic             bus_reset_b_s;
  logic             strb_s;
  logic             bres_s;
  logic             decode_s;
  logic [QW-1:0]    qcnt_inc_s;

  state_e           state_q;
  logic [QW-1:0]    qcnt_q;
  logic             cfg_we_q;
  logic [CFG_W-1:0] cfg_data_q;
  logic [CFG_W-1:0] ramcfg_q;
  logic [CNT_W-1:0] wr_count_q;
  logic [CNT_W-1:0] rej_count_q;
  logic [CNT_W-1:0] glitch_count_q;

  assign raw_s = {BUS_RESET_B, A15, WR_B, IOREQ_B, D};

  for (genvar i = 0; i < NBITS; i++) begin : g_sync
    cpc_sync_bit #(.N(SYNC_STAGES)) u_sync (
      .clk_i (CLK),
      .rst_i (RESET),
      .d_i   (raw_s[i]),
      .q_o   (sync_s[i])
    );
  end

  assign d_s           = sync_s[7:0];
  assign ioreq_b_s     = sync_s[8];
  assign wr_b_s        = sync_s[9];
  assign a15_s         = sync_s[10];
  assign bus_reset_b_s = sync_s[11];

  assign strb_s     = ~ioreq_b_s & ~wr_b_s;
  assign bres_s     = ~bus_reset_b_s;
  assign decode_s   = cfg_decode(a15_s, d_s);
  assign qcnt_inc_s = qcnt_q + QW'(1);

  // Capture FSM with all outputs registered; bus reset beats a capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      qcnt_q         <= '0;
      cfg_we_q       <= 1'b0;
      cfg_data_q     <= '0;
      ramcfg_q       <= '0;
      wr_count_q     <= '0;
      rej_count_q    <= '0;
      glitch_count_q <= '0;
    end else begin
      cfg_we_q <= 1'b0;
      if (bres_s) begin
        ramcfg_q <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (strb_s) begin
            if (FILTER_LEN == 1) begin
              state_q <= ST_CAPTURE;
            end else begin
              state_q <= ST_QUAL;
              qcnt_q  <= QW'(1);
            end
          end
        end
        ST_QUAL: begin
          if (strb_s) begin
            qcnt_q <= qcnt_inc_s;
            if (qcnt_inc_s == QW'(FILTER_LEN)) begin
              state_q <= ST_CAPTURE;
            end
          end else begin
            glitch_count_q <= glitch_count_q + CNT_W'(1);
            qcnt_q         <= '0;
            state_q        <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_HOLD;
          qcnt_q  <= '0;
          if (!bres_s) begin
            if (decode_s) begin
              cfg_we_q   <= 1'b1;
              cfg_data_q <= d_s[CFG_W-1:0];
              ramcfg_q   <= d_s[CFG_W-1:0];
              wr_count_q <= wr_count_q + CNT_W'(1);
            end else begin
              rej_count_q <= rej_count_q + CNT_W'(1);
            end
          end
        end
        // One bus write yields one capture: wait for the strobe to release.
        ST_HOLD: begin
          if (!strb_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          qcnt_q  <= '0;
        end
      endcase
    end
  end

  assign cfg_we       = cfg_we_q;
  assign cfg_data     = cfg_data_q;
  assign ramcfg       = ramcfg_q;
  assign busy         = (state_q != ST_IDLE);
  assign wr_count     = wr_count_q;
  assign rej_count    = rej_count_q;
  assign glitch_count = glitch_count_q;

endmodule

// File: tb/tb_cpc_ioreq_cfg_capture.sv
// Randomised scoreboard bench: stimulus pushes expected pulses and state
// snapshots into queues, an independent monitor compares them against the DUT.
module tb_cpc_ioreq_cfg_capture;

  localparam int S = 2;
  localparam int F = 3;
  localparam int W = 8;

  logic       CLK;
  logic       RESET;
  logic       IOREQ_B;
  logic       WR_B;
  logic       A15;
  logic [7:0] D;
  logic       BUS_RESET_B;
  logic       cfg_we;
  logic [5:0] cfg_data;
  logic [5:0] ramcfg;
  logic       busy;
  logic [W-1:0] wr_count;
  logic [W-1:0] rej_count;
  logic [W-1:0] glitch_count;

  cpc_ioreq_cfg_capture #(.SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IOREQ_B      (IOREQ_B),
    .WR_B         (WR_B),
    .A15          (A15),
    .D            (D),
    .BUS_RESET_B  (BUS_RESET_B),
    .cfg_we       (cfg_we),
    .cfg_data     (cfg_data),
    .ramcfg       (ramcfg),
    .busy         (busy),
    .wr_count     (wr_count),
    .rej_count    (rej_count),
    .glitch_count (glitch_count)
  );

  typedef struct {
    int         cyc;
    logic [5:0] data;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [5:0] ram;
    logic [5:0] cfg;
    logic [7:0] wr;
    logic [7:0] rej;
    logic [7:0] gl;
  } st_t;

  typedef struct {
    int   cyc;
    logic val;
  } bz_t;

  ev_t ev_q[$];
  st_t st_q[$];
  bz_t bz_q[$];

  int  cyc    = 0;
  int  n_chk  = 0;
  int  n_fail = 0;
  bit  done   = 1'b0;

  // Reference state: what the configuration register world should look like.
  logic [5:0] m_ram;
  logic [5:0] m_cfg;
  logic [7:0] m_wr;
  logic [7:0] m_rej;
  logic [7:0] m_gl;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations when the DUT pulses or a snapshot is due.
  initial begin : monitor
    ev_t e;
    st_t s;
    bz_t b;
    bit  prev_we;
    prev_we = 1'b0;
    forever begin
      @(negedge CLK);
      if (cfg_we === 1'b1) begin
        chk("we_back_to_back", {31'd0, prev_we}, 32'd0);
        if (ev_q.size() == 0) begin
          n_chk  = n_chk + 1;
          n_fail = n_fail + 1;
          $display("FAIL unexpected_we at cycle %0d: got pulse expected none", cyc);
        end else begin
          e = ev_q.pop_front();
          chk("we_cycle", cyc, e.cyc);
          chk("cfg_data_at_we", {26'd0, cfg_data}, {26'd0, e.data});
          chk("ramcfg_at_we", {26'd0, ramcfg}, {26'd0, e.data});
        end
      end
      prev_we = (cfg_we === 1'b1);
      while (ev_q.size() != 0 && ev_q[0].cyc < cyc) begin
        e = ev_q.pop_front();
        n_chk  = n_chk + 1;
        n_fail = n_fail + 1;
        $display("FAIL missed_we: got no pulse expected one at cycle %0d data %0h", e.cyc, e.data);
      end
      while (st_q.size() != 0 && st_q[0].cyc <= cyc) begin
        s = st_q.pop_front();
        chk("snap_cycle", cyc, s.cyc);
        chk("snap_ramcfg", {26'd0, ramcfg}, {26'd0, s.ram});
        chk("snap_cfg_data", {26'd0, cfg_data}, {26'd0, s.cfg});
        chk("snap_wr_count", {24'd0, wr_count}, {24'd0, s.wr});
        chk("snap_rej_count", {24'd0, rej_count}, {24'd0, s.rej});
        chk("snap_glitch_count", {24'd0, glitch_count}, {24'd0, s.gl});
        chk("snap_busy_idle", {31'd0, busy}, 32'd0);
        chk("snap_we_low", {31'd0, cfg_we}, 32'd0);
      end
      while (bz_q.size() != 0 && bz_q[0].cyc <= cyc) begin
        b = bz_q.pop_front();
        chk("busy_timing", {31'd0, busy}, {31'd0, b.val});
      end
      if (done || cyc > 60000) begin
        if (!done) begin
          n_chk  = n_chk + 1;
          n_fail = n_fail + 1;
          $display("FAIL timeout: got cycle %0d expected stimulus to finish", cyc);
        end
        chk("pending_events", ev_q.size(), 32'd0);
        chk("pending_snaps", st_q.size(), 32'd0);
        chk("pending_busy", bz_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  task automatic push_snap(input int at);
    st_t s;
    s.cyc = at;
    s.ram = m_ram;
    s.cfg = m_cfg;
    s.wr  = m_wr;
    s.rej = m_rej;
    s.gl  = m_gl;
    st_q.push_back(s);
  endtask

  task automatic push_busy(input int at, input logic v);
    bz_t b;
    b.cyc = at;
    b.val = v;
    bz_q.push_back(b);
  endtask

  task automatic model_clear();
    m_ram = 6'd0;
    m_cfg = 6'd0;
    m_wr  = 8'd0;
    m_rej = 8'd0;
    m_gl  = 8'd0;
  endtask

  // One bus I/O write: strobe low for len samples; optional bus-reset pulse
  // timed so the synchronised bus reset lands on the capture decision.
  task automatic xact(input logic a15, input logic [7:0] d, input int len, input bit bres);
    int  c;
    int  we_c;
    int  t_end;
    int  last_hi;
    ev_t e;
    c     = cyc;
    we_c  = c + 1 + S + F;
    t_end = c + len + S + F + 6;
    if (len >= F) begin
      if (bres) begin
        m_ram = 6'd0;
      end else if (a15 == 1'b0 && d[7:6] == 2'b11) begin
        e.cyc  = we_c;
        e.data = d[5:0];
        ev_q.push_back(e);
        m_wr  = m_wr + 8'd1;
        m_cfg = d[5:0];
        m_ram = d[5:0];
      end else begin
        m_rej = m_rej + 8'd1;
      end
    end else begin
      m_gl = m_gl + 8'd1;
    end
    if (bres) begin
      m_ram = 6'd0;
    end
    last_hi = c + len + 2 + ((len == F) ? 1 : 0);
    push_busy(last_hi, 1'b1);
    push_busy(last_hi + 1, 1'b0);
    push_snap(t_end);
    A15     = a15;
    D       = d;
    IOREQ_B = 1'b0;
    WR_B    = 1'b0;
    while (cyc < t_end) begin
      @(negedge CLK);
      if (cyc == c + len) begin
        IOREQ_B = 1'b1;
        WR_B    = 1'b1;
      end
      BUS_RESET_B = (bres && cyc == we_c - S - 1) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic reset_in_qual();
    int c;
    c       = cyc;
    A15     = 1'b0;
    D       = 8'hC7;
    IOREQ_B = 1'b0;
    WR_B    = 1'b0;
    push_busy(c + 3, 1'b1);
    while (cyc < c + 3) @(negedge CLK);
    RESET   = 1'b1;
    IOREQ_B = 1'b1;
    WR_B    = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    model_clear();
    push_snap(cyc + 1);
    repeat (3) @(negedge CLK);
  endtask

  initial begin : stimulus
    int         len;
    logic       a15;
    logic [7:0] d;
    bit         bres;
    RESET       = 1'b1;
    IOREQ_B     = 1'b1;
    WR_B        = 1'b1;
    A15         = 1'b1;
    D           = 8'hFF;
    BUS_RESET_B = 1'b1;
    model_clear();
    @(negedge CLK);
    push_snap(cyc + 1);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    push_snap(cyc + 2);
    repeat (3) @(negedge CLK);

    xact(1'b0, 8'hC5, 10, 1'b0);
    xact(1'b0, 8'h85, 6, 1'b0);
    xact(1'b1, 8'hC3, 6, 1'b0);
    xact(1'b0, 8'hC9, 2, 1'b0);
    xact(1'b0, 8'hC7, 40, 1'b0);
    xact(1'b0, 8'hC2, 6, 1'b1);
    xact(1'b0, 8'hC1, 5, 1'b0);
    xact(1'b0, 8'hE6, 3, 1'b0);
    xact(1'b0, 8'hDA, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      len  = (i % 8 == 7) ? 20 : $urandom_range(1, 8);
      a15  = ($urandom_range(0, 3) == 0);
      d    = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[7:6] = 2'b11;
      bres = ($urandom_range(0, 7) == 0);
      xact(a15, d, len, bres);
    end

    reset_in_qual();
    for (int i = 0; i < 256; i++) begin
      d = 8'hC0 | 8'($urandom_range(0, 63));
      xact(1'b0, d, 4, 1'b0);
    end
    push_snap(cyc + 2);
    repeat (4) @(negedge CLK);
    done = 1'b1;
  end

endmodule
